// File: rtl/wb_sequencer.sv
// wb_sequencer: write-back sequencer for the single-cycle core.
//   Selects the register-data source, drives the register-file write enable
//   and write address, and stalls the PC while a load waits on a
//   variable-latency data memory. ALU and link results are written back in
//   the cycle they are presented. A load that gets no response within
//   TIMEOUT_CYCLES cycles of LOAD_WAIT is aborted, and this sets a sticky flag.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   instr_valid     decoded instruction present this cycle
//   wb_kind[1:0]    00 ALU, 01 load, 10 link (PC+4), 11 no write-back
//   rd[4:0]         destination register of the current instruction
//   mem_rsp_valid   data memory read data valid
//   dmem_req        one-cycle load request pulse
//   reg_data_src    register-data mux select: 00 ALU, 01 memory, 10 PC+4
//   reg_write       register-file write enable (never asserted for x0)
//   reg_waddr[4:0]  register-file write address
//   pc_stall        hold PC and current instruction
//   load_timeout    sticky: a load was aborted (cleared only by reset)
module wb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [1:0] wb_kind,
  input  logic [4:0] rd,
  input  logic       mem_rsp_valid,
  output logic       dmem_req,
  output logic [1:0] reg_data_src,
  output logic       reg_write,
  output logic [4:0] reg_waddr,
  output logic       pc_stall,
  output logic       load_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_LOAD_WAIT = 1'b1;

  logic [0:0]    state, nxt_state;
  logic [4:0]    rd_q, nxt_rd;
  logic [CW-1:0] wait_cnt, nxt_cnt;
  logic          to_q, nxt_to;

  assign load_timeout = to_q;

  always_comb begin
    dmem_req     = 1'b0;
    reg_data_src = 2'b00;
    reg_write    = 1'b0;
    reg_waddr    = '0;
    pc_stall     = 1'b0;
    nxt_state    = state;
    nxt_rd       = rd_q;
    nxt_cnt      = wait_cnt;
    nxt_to       = to_q;

    case (state)
      S_IDLE: begin
        // mem_rsp_valid is deliberately ignored here: a response with no
        // outstanding load must not write anything.
        if (instr_valid) begin
          case (wb_kind)
            2'b00, 2'b10: begin
              reg_data_src = wb_kind;
              reg_waddr    = rd;
              reg_write    = (rd != 5'd0);
            end
            2'b01: begin
              dmem_req  = 1'b1;
              pc_stall  = 1'b1;
              nxt_rd    = rd;
              nxt_cnt   = '0;
              nxt_state = S_LOAD_WAIT;
            end
            default: ;
          endcase
        end
      end
      S_LOAD_WAIT: begin
        // A response in the last allowed cycle takes priority over the abort.
        if (mem_rsp_valid) begin
          reg_data_src = 2'b01;
          reg_waddr    = rd_q;
          reg_write    = (rd_q != 5'd0);
          nxt_state    = S_IDLE;
        end else if (wait_cnt == LAST_CNT) begin
          nxt_to    = 1'b1;
          nxt_state = S_IDLE;
        end else begin
          pc_stall = 1'b1;
          nxt_cnt  = wait_cnt + 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    // Outputs are held low for the whole time reset is asserted, even though
    // state is already IDLE, so an instruction on the inputs cannot write.
    if (!rst_n) begin
      dmem_req     = 1'b0;
      reg_data_src = 2'b00;
      reg_write    = 1'b0;
      reg_waddr    = '0;
      pc_stall     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_q     <= '0;
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      state    <= nxt_state;
      rd_q     <= nxt_rd;
      wait_cnt <= nxt_cnt;
      to_q     <= nxt_to;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [1:0] wb_kind;
  logic [4:0] rd;
  logic       mem_rsp_valid;
  logic       dmem_req;
  logic [1:0] reg_data_src;
  logic       reg_write;
  logic [4:0] reg_waddr;
  logic       pc_stall;
  logic       load_timeout;

  wb_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .wb_kind      (wb_kind),
    .rd           (rd),
    .mem_rsp_valid(mem_rsp_valid),
    .dmem_req     (dmem_req),
    .reg_data_src (reg_data_src),
    .reg_write    (reg_write),
    .reg_waddr    (reg_waddr),
    .pc_stall     (pc_stall),
    .load_timeout (load_timeout)
  );

  typedef struct packed {
    logic       req;
    logic [1:0] src;
    logic       wr;
    logic [4:0] waddr;
    logic       stall;
    logic       to;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic req, input logic [1:0] src,
                              input logic wr, input logic [4:0] waddr,
                              input logic stall, input logic to);
    exp_t e;
    e.req = req; e.src = src; e.wr = wr; e.waddr = waddr;
    e.stall = stall; e.to = to;
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge, queue the expected
  // outputs, then pop and compare them mid-cycle.
  task automatic step(input logic r, input logic iv, input logic [1:0] k,
                      input logic [4:0] d, input logic rsp, input exp_t e,
                      input string tag);
    exp_t  obs;
    exp_t  want;
    string t;
    @(posedge clk);
    #1;
    rst_n = r; instr_valid = iv; wb_kind = k; rd = d; mem_rsp_valid = rsp;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #3;
    obs  = mk(dmem_req, reg_data_src, reg_write, reg_waddr, pc_stall, load_timeout);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed req=%b src=%b wr=%b waddr=%0d stall=%b to=%b, expected req=%b src=%b wr=%b waddr=%0d stall=%b to=%b",
             t, obs.req, obs.src, obs.wr, obs.waddr, obs.stall, obs.to,
             want.req, want.src, want.wr, want.waddr, want.stall, want.to);
    end
  endtask

  exp_t z;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; wb_kind = 2'b00; rd = '0; mem_rsp_valid = 1'b0;
    z = mk(0, 2'b00, 0, 5'd0, 0, 0);

    // Reset overrides a valid ALU instruction, then same inputs write x5.
    step(0, 1, 2'b00, 5'd5, 0, z,                          "reset_alu");
    step(0, 1, 2'b00, 5'd5, 0, z,                          "reset_alu2");
    step(1, 1, 2'b00, 5'd5, 0, mk(0, 2'b00, 1, 5'd5, 0, 0), "alu_x5");
    // Link x1, then ALU to x0 (suppressed).
    step(1, 1, 2'b10, 5'd1, 0, mk(0, 2'b10, 1, 5'd1, 0, 0), "link_x1");
    step(1, 1, 2'b00, 5'd0, 0, z,                          "alu_x0");
    // Link to x0: source still shown, no write.
    step(1, 1, 2'b10, 5'd0, 0, mk(0, 2'b10, 0, 5'd0, 0, 0), "link_x0");

    // Load x7, response 3 cycles after issue; held inputs changed to prove they are ignored.
    step(1, 1, 2'b01, 5'd7,  0, mk(1, 2'b00, 0, 5'd0, 1, 0), "ld7_issue");
    step(1, 1, 2'b00, 5'd12, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld7_wait1");
    step(1, 1, 2'b01, 5'd12, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld7_wait2");
    step(1, 1, 2'b10, 5'd12, 1, mk(0, 2'b01, 1, 5'd7, 0, 0), "ld7_rsp");

    // Back-to-back minimum-cost load to x0: response writes nothing.
    step(1, 1, 2'b01, 5'd0, 0, mk(1, 2'b00, 0, 5'd0, 1, 0), "ld0_issue");
    step(1, 1, 2'b01, 5'd0, 1, mk(0, 2'b01, 0, 5'd0, 0, 0), "ld0_rsp");

    // Load x9, response on the 4th LOAD_WAIT cycle wins over the timeout.
    step(1, 1, 2'b01, 5'd9, 0, mk(1, 2'b00, 0, 5'd0, 1, 0), "ld9r_issue");
    step(1, 0, 2'b00, 5'd0, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld9r_w1");
    step(1, 0, 2'b00, 5'd0, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld9r_w2");
    step(1, 0, 2'b00, 5'd0, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld9r_w3");
    step(1, 0, 2'b00, 5'd0, 1, mk(0, 2'b01, 1, 5'd9, 0, 0), "ld9r_rsp_last");
    step(1, 0, 2'b00, 5'd0, 0, z,                          "ld9r_no_timeout");

    // Load x9 with no response: aborted on the 4th LOAD_WAIT cycle.
    step(1, 1, 2'b01, 5'd9, 0, mk(1, 2'b00, 0, 5'd0, 1, 0), "ld9t_issue");
    step(1, 1, 2'b01, 5'd9, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld9t_w1");
    step(1, 1, 2'b01, 5'd9, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld9t_w2");
    step(1, 1, 2'b01, 5'd9, 0, mk(0, 2'b00, 0, 5'd0, 1, 0), "ld9t_w3");
    step(1, 0, 2'b00, 5'd0, 0, z,                          "ld9t_abort");
    step(1, 0, 2'b00, 5'd0, 0, mk(0, 2'b00, 0, 5'd0, 0, 1), "timeout_set");
    // Sticky flag survives later traffic, including a late response in IDLE.
    step(1, 1, 2'b10, 5'd4, 1, mk(0, 2'b10, 1, 5'd4, 0, 1), "timeout_sticky");

    // Load x3, reset mid-wait: outputs drop at once, no write after release.
    step(1, 1, 2'b01, 5'd3, 0, mk(1, 2'b00, 0, 5'd0, 1, 1), "ld3_issue");
    step(1, 1, 2'b01, 5'd3, 0, mk(0, 2'b00, 0, 5'd0, 1, 1), "ld3_wait");
    step(0, 1, 2'b01, 5'd3, 1, z,                          "ld3_reset");
    step(1, 0, 2'b00, 5'd0, 1, z,                          "ld3_after_rst");

    // Spurious responses in IDLE.
    step(1, 1, 2'b11, 5'd6, 1, z,                          "spurious_nowb");
    step(1, 0, 2'b01, 5'd6, 1, z,                          "spurious_novalid");
    step(1, 1, 2'b00, 5'd31, 0, mk(0, 2'b00, 1, 5'd31, 0, 0), "alu_x31");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
